// File: rtl/interrupt_controller.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : interrupt_controller
// Description : Interrupt front-end for the single-cycle MIPS core.
//               Synchronizes three asynchronous request lines, edge-detects
//               them into sticky pending bits, applies a software mask,
//               priority-selects one source and presents a request plus
//               entry vector. The in-service source is tracked until eret,
//               so interrupts never nest.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               irq_raw[2:0]    - async level requests (bit 2 = highest)
//               mask_we/din     - mask register write
//               ovr_clr[2:0]    - write-1-to-clear overrun flags
//               irq_ack, eret   - CPU take / exception return strobes
//               irq_req, irq_vector, mask, pending, in_service, overrun
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module interrupt_controller #(
   parameter logic [31:0] ENTRY1 = 32'h0000_0000,
   parameter logic [31:0] ENTRY2 = 32'h0000_0000,
   parameter logic [31:0] ENTRY3 = 32'h0000_036c
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  irq_raw,
   input  logic        mask_we,
   input  logic [2:0]  mask_din,
   input  logic [2:0]  ovr_clr,
   input  logic        irq_ack,
   input  logic        eret,
   output logic        irq_req,
   output logic [31:0] irq_vector,
   output logic [2:0]  mask,
   output logic [2:0]  pending,
   output logic [2:0]  in_service,
   output logic [2:0]  overrun
);

   typedef enum logic [0:0] {
      S_IDLE    = 1'b0,
      S_SERVICE = 1'b1
   } state_t;

   state_t      r_state;
   state_t      w_state_next;

   logic [2:0]  r_sync1;
   logic [2:0]  r_sync2;
   logic [2:0]  r_prev;
   logic [2:0]  r_pending;
   logic [2:0]  r_overrun;
   logic [2:0]  r_mask;
   logic [2:0]  r_in_service;

   logic [2:0]  w_edge;
   logic [2:0]  w_eligible;
   logic [2:0]  w_sel;
   logic [31:0] w_sel_vector;
   logic        w_take;
   logic [2:0]  w_ack_vec;

   assign w_edge     = r_sync2 & ~r_prev;
   assign w_eligible = r_pending & ~r_mask;

   // Fixed priority: bit 2 > bit 1 > bit 0.
   always_comb begin
      w_sel        = 3'b000;
      w_sel_vector = 32'h0000_0000;
      if (w_eligible[2]) begin
         w_sel        = 3'b100;
         w_sel_vector = ENTRY1;
      end else if (w_eligible[1]) begin
         w_sel        = 3'b010;
         w_sel_vector = ENTRY2;
      end else if (w_eligible[0]) begin
         w_sel        = 3'b001;
         w_sel_vector = ENTRY3;
      end
   end

   // Next-state and outputs. Nothing is presented while a source is in
   // service, which is what prevents nesting.
   always_comb begin
      w_state_next = r_state;
      irq_req      = 1'b0;
      irq_vector   = 32'h0000_0000;
      w_take       = 1'b0;
      case (r_state)
         S_IDLE: begin
            irq_req    = |w_eligible;
            irq_vector = w_sel_vector;
            if (irq_ack && irq_req) begin
               w_take       = 1'b1;
               w_state_next = S_SERVICE;
            end
         end
         S_SERVICE: begin
            if (eret) begin
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   assign w_ack_vec = w_take ? w_sel : 3'b000;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1      <= 3'b000;
         r_sync2      <= 3'b000;
         r_prev       <= 3'b000;
         r_pending    <= 3'b000;
         r_overrun    <= 3'b000;
         r_mask       <= 3'b000;
         r_in_service <= 3'b000;
      end else begin
         r_sync1   <= irq_raw;
         r_sync2   <= r_sync1;
         r_prev    <= r_sync2;
         // A new edge on the source being acked keeps its pending bit set.
         r_pending <= (r_pending & ~w_ack_vec) | w_edge;
         // Set takes priority over a simultaneous clear.
         r_overrun <= (r_overrun & ~ovr_clr) | (w_edge & r_pending & ~w_ack_vec);
         if (mask_we) begin
            r_mask <= mask_din;
         end
         if (w_take) begin
            r_in_service <= w_sel;
         end else if (r_state == S_SERVICE && eret) begin
            r_in_service <= 3'b000;
         end
      end
   end

   assign mask       = r_mask;
   assign pending    = r_pending;
   assign in_service = r_in_service;
   assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_controller.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_interrupt_controller
// Description : Self-checking bench for interrupt_controller. A cycle table
//               of inputs and hand-computed outputs is applied one row per
//               clock, followed by a reset-during-service sequence.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_interrupt_controller;

   localparam logic [31:0] C_E1 = 32'h0000_0000;
   localparam logic [31:0] C_E2 = 32'h0000_0000;
   localparam logic [31:0] C_E3 = 32'h0000_036c;

   logic        clk;
   logic        rst;
   logic [2:0]  irq_raw;
   logic        mask_we;
   logic [2:0]  mask_din;
   logic [2:0]  ovr_clr;
   logic        irq_ack;
   logic        eret;
   logic        irq_req;
   logic [31:0] irq_vector;
   logic [2:0]  mask;
   logic [2:0]  pending;
   logic [2:0]  in_service;
   logic [2:0]  overrun;

   int n_checks;
   int n_fail;

   typedef struct {
      logic        rst;
      logic [2:0]  raw;
      logic        mwe;
      logic [2:0]  mdin;
      logic [2:0]  oclr;
      logic        ack;
      logic        eret;
      logic        req;
      logic [31:0] vec;
      logic [2:0]  mask;
      logic [2:0]  pend;
      logic [2:0]  insvc;
      logic [2:0]  ovr;
   } vec_t;

   vec_t tbl[$];

   interrupt_controller #(
      .ENTRY1(C_E1),
      .ENTRY2(C_E2),
      .ENTRY3(C_E3)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .irq_raw   (irq_raw),
      .mask_we   (mask_we),
      .mask_din  (mask_din),
      .ovr_clr   (ovr_clr),
      .irq_ack   (irq_ack),
      .eret      (eret),
      .irq_req   (irq_req),
      .irq_vector(irq_vector),
      .mask      (mask),
      .pending   (pending),
      .in_service(in_service),
      .overrun   (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int row, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", name, row, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic [2:0] raw, input logic mwe,
                      input logic [2:0] mdin, input logic [2:0] oclr, input logic ack,
                      input logic er, input logic req, input logic [31:0] vec,
                      input logic [2:0] m, input logic [2:0] p, input logic [2:0] s,
                      input logic [2:0] o);
      vec_t v;
      v.rst = r;   v.raw = raw; v.mwe = mwe; v.mdin = mdin; v.oclr = oclr;
      v.ack = ack; v.eret = er; v.req = req; v.vec = vec;  v.mask = m;
      v.pend = p;  v.insvc = s; v.ovr = o;
      tbl.push_back(v);
   endtask

   // Drive one row's inputs on the falling edge, then check outputs just
   // after the following rising edge.
   task automatic run_row(input vec_t v, input int row);
      @(negedge clk);
      rst      = v.rst;
      irq_raw  = v.raw;
      mask_we  = v.mwe;
      mask_din = v.mdin;
      ovr_clr  = v.oclr;
      irq_ack  = v.ack;
      eret     = v.eret;
      @(posedge clk);
      #1;
      chk("irq_req",    row, {31'd0, irq_req},   {31'd0, v.req});
      chk("irq_vector", row, irq_vector,         v.vec);
      chk("mask",       row, {29'd0, mask},      {29'd0, v.mask});
      chk("pending",    row, {29'd0, pending},   {29'd0, v.pend});
      chk("in_service", row, {29'd0, in_service},{29'd0, v.insvc});
      chk("overrun",    row, {29'd0, overrun},   {29'd0, v.ovr});
   endtask

   initial begin
      vec_t v;
      n_checks = 0;
      n_fail   = 0;
      rst = 1'b1; irq_raw = 3'b000; mask_we = 1'b0; mask_din = 3'b000;
      ovr_clr = 3'b000; irq_ack = 1'b0; eret = 1'b0;

      //   rst raw     mwe mdin    oclr    ack er  req vec   mask    pend    insvc   ovr
      // Reset, then a 2-cycle pulse on source 3
      add(1, 3'b000, 0, 3'b000, 3'b000, 0, 0, 0, C_E1, 3'b000, 3'b000, 3'b000, 3'b000); // 0
      add(0, 3'b001, 0, 3'b000, 3'b000, 0, 0, 0, C_E1, 3'b000, 3'b000, 3'b000, 3'b000);
      add(0, 3'b001, 0, 3'b000, 3'b000, 0, 0, 0, C_E1, 3'b000, 3'b000, 3'b000, 3'b000);
      add(0, 3'b000, 0, 3'b000, 3'b000, 0, 0, 1, C_E3, 3'b000, 3'b001, 3'b000, 3'b000);
      add(0, 3'b000, 0, 3'b000, 3'b000, 1, 0, 0, C_E1, 3'b000, 3'b000, 3'b001, 3'b000);
      add(0, 3'b000, 0, 3'b000, 3'b000, 0, 1, 0, C_E1, 3'b000, 3'b000, 3'b000, 3'b000); // 5
      // Simultaneous 101: source 1 first, then source 3 right after eret
      add(0, 3'b101, 0, 3'b000, 3'b000, 0, 0, 0, C_E1, 3'b000, 3'b000, 3'b000, 3'b000);
      add(0, 3'b101, 0, 3'b000, 3'b000, 0, 0, 0, C_E1, 3'b000, 3'b000, 3'b000, 3'b000);
      add(0, 3'b101, 0, 3'b000, 3'b000, 0, 0, 1, C_E1, 3'b000, 3'b101, 3'b000, 3'b000);
      add(0, 3'b101, 0, 3'b000, 3'b000, 1, 0, 0, C_E1, 3'b000, 3'b001, 3'b100, 3'b000);
      add(0, 3'b000, 0, 3'b000, 3'b000, 0, 1, 1, C_E3, 3'b000, 3'b001, 3'b000, 3'b000); // 10
      add(0, 3'b000, 0, 3'b000, 3'b000, 1, 0, 0, C_E1, 3'b000, 3'b000, 3'b001, 3'b000);
      add(0, 3'b000, 0, 3'b000, 3'b000, 0, 1, 0, C_E1, 3'b000, 3'b000, 3'b000, 3'b000);
      // Masked source 1 becomes visible once the mask is written to 0
      add(0, 3'b100, 1, 3'b100, 3'b000, 0, 0, 0, C_E1, 3'b100, 3'b000, 3'b000, 3'b000);
      add(0, 3'b100, 0, 3'b000, 3'b000, 0, 0, 0, C_E1, 3'b100, 3'b000, 3'b000, 3'b000);
      add(0, 3'b100, 0, 3'b000, 3'b000, 0, 0, 0, C_E1, 3'b100, 3'b100, 3'b000, 3'b000); // 15
      add(0, 3'b100, 1, 3'b000, 3'b000, 0, 0, 1, C_E1, 3'b000, 3'b100, 3'b000, 3'b000);
      add(0, 3'b000, 0, 3'b000, 3'b000, 1, 0, 0, C_E1, 3'b000, 3'b000, 3'b100, 3'b000);
      add(0, 3'b000, 0, 3'b000, 3'b000, 0, 1, 0, C_E1, 3'b000, 3'b000, 3'b000, 3'b000);
      // Source 1 arrives while source 3 is in service; held off until eret
      add(0, 3'b001, 0, 3'b000, 3'b000, 0, 0, 0, C_E1, 3'b000, 3'b000, 3'b000, 3'b000);
      add(0, 3'b001, 0, 3'b000, 3'b000, 0, 0, 0, C_E1, 3'b000, 3'b000, 3'b000, 3'b000); // 20
      add(0, 3'b000, 0, 3'b000, 3'b000, 0, 0, 1, C_E3, 3'b000, 3'b001, 3'b000, 3'b000);
      add(0, 3'b100, 0, 3'b000, 3'b000, 1, 0, 0, C_E1, 3'b000, 3'b000, 3'b001, 3'b000);
      add(0, 3'b100, 0, 3'b000, 3'b000, 0, 0, 0, C_E1, 3'b000, 3'b000, 3'b001, 3'b000);
      add(0, 3'b100, 0, 3'b000, 3'b000, 0, 0, 0, C_E1, 3'b000, 3'b100, 3'b001, 3'b000);
      add(0, 3'b100, 0, 3'b000, 3'b000, 1, 0, 0, C_E1, 3'b000, 3'b100, 3'b001, 3'b000); // 25
      add(0, 3'b100, 0, 3'b000, 3'b000, 0, 1, 1, C_E1, 3'b000, 3'b100, 3'b000, 3'b000);
      add(0, 3'b000, 0, 3'b000, 3'b000, 1, 0, 0, C_E1, 3'b000, 3'b000, 3'b100, 3'b000);
      add(0, 3'b000, 0, 3'b000, 3'b000, 0, 1, 0, C_E1, 3'b000, 3'b000, 3'b000, 3'b000);
      // Overrun set, cleared, then clear coinciding with a new overrun edge
      add(0, 3'b001, 0, 3'b000, 3'b000, 0, 0, 0, C_E1, 3'b000, 3'b000, 3'b000, 3'b000);
      add(0, 3'b000, 0, 3'b000, 3'b000, 0, 0, 0, C_E1, 3'b000, 3'b000, 3'b000, 3'b000); // 30
      add(0, 3'b000, 0, 3'b000, 3'b000, 0, 0, 1, C_E3, 3'b000, 3'b001, 3'b000, 3'b000);
      add(0, 3'b001, 0, 3'b000, 3'b000, 0, 0, 1, C_E3, 3'b000, 3'b001, 3'b000, 3'b000);
      add(0, 3'b000, 0, 3'b000, 3'b000, 0, 0, 1, C_E3, 3'b000, 3'b001, 3'b000, 3'b000);
      add(0, 3'b000, 0, 3'b000, 3'b000, 0, 0, 1, C_E3, 3'b000, 3'b001, 3'b000, 3'b001);
      add(0, 3'b000, 0, 3'b000, 3'b001, 0, 0, 1, C_E3, 3'b000, 3'b001, 3'b000, 3'b000); // 35
      add(0, 3'b001, 0, 3'b000, 3'b000, 0, 0, 1, C_E3, 3'b000, 3'b001, 3'b000, 3'b000);
      add(0, 3'b000, 0, 3'b000, 3'b000, 0, 0, 1, C_E3, 3'b000, 3'b001, 3'b000, 3'b000);
      add(0, 3'b000, 0, 3'b000, 3'b001, 0, 0, 1, C_E3, 3'b000, 3'b001, 3'b000, 3'b001);
      // Edge and ack of the same source together: pending stays, no overrun
      add(0, 3'b001, 0, 3'b000, 3'b000, 0, 0, 1, C_E3, 3'b000, 3'b001, 3'b000, 3'b001);
      add(0, 3'b000, 0, 3'b000, 3'b000, 0, 0, 1, C_E3, 3'b000, 3'b001, 3'b000, 3'b001); // 40
      add(0, 3'b000, 0, 3'b000, 3'b000, 1, 0, 0, C_E1, 3'b000, 3'b001, 3'b001, 3'b001);
      // eret together with ack: back to idle, request re-presented
      add(0, 3'b000, 0, 3'b000, 3'b001, 1, 1, 1, C_E3, 3'b000, 3'b001, 3'b000, 3'b000);
      add(0, 3'b000, 0, 3'b000, 3'b000, 1, 0, 0, C_E1, 3'b000, 3'b000, 3'b001, 3'b000);

      for (int i = 0; i < tbl.size(); i++) begin
         run_row(tbl[i], i);
      end

      // Reset in the middle of service with source 2 pending; the held
      // level must re-create pending three edges after release, and an ack
      // with nothing presented must be ignored.
      v = tbl[0];
      v.rst = 1'b0; v.raw = 3'b010;
      v.insvc = 3'b001;
      run_row(v, 100);
      run_row(v, 101);
      v.pend = 3'b010;
      run_row(v, 102);
      v.rst = 1'b1; v.pend = 3'b000; v.insvc = 3'b000;
      run_row(v, 103);
      v.rst = 1'b0; v.ack = 1'b1;
      run_row(v, 104);
      v.ack = 1'b0;
      run_row(v, 105);
      v.pend = 3'b010; v.req = 1'b1; v.vec = C_E2;
      run_row(v, 106);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
